// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC/FSM driving a req/gnt/rvalid imem port, a small
// fetch FIFO with fall-through, and a registered IF/ID buffer toward decode.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_ip,
  input  logic        redirect_valid_ip,
  input  logic [31:0] redirect_pc_ip,
  output logic        instr_req_op,
  output logic [31:0] instr_addr_op,
  input  logic        instr_gnt_ip,
  input  logic        instr_rvalid_ip,
  input  logic [31:0] instr_rdata_ip,
  output logic        instr_data_valid_op,
  output logic [31:0] instr_data_op,
  output logic [31:0] pc_op,
  output logic [31:0] pc4_op
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_FULL} state_t;

  state_t        state, state_n;
  logic          armed;
  logic [31:0]   fetch_pc, fetch_pc_n, out_pc;
  logic          discard, discard_n;

  logic [FIFO_DEPTH-1:0][31:0] fifo_instr, fifo_pc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;

  logic gnt_ok, rsp_ok, fall, push, pop, has_space;

  // armed keeps req low during the first cycle out of reset
  assign instr_req_op  = armed && (state == S_FETCH);
  assign instr_addr_op = fetch_pc;

  assign gnt_ok    = instr_req_op && instr_gnt_ip;
  assign rsp_ok    = (state == S_WAIT) && instr_rvalid_ip && !discard && !redirect_valid_ip;
  assign fall      = rsp_ok && !stall_ip && (count == '0);
  assign push      = rsp_ok && !fall;
  assign pop       = !redirect_valid_ip && !stall_ip && (count != '0);
  assign count_nxt = redirect_valid_ip ? '0 : (count + CW'(push) - CW'(pop));
  assign has_space = count_nxt < CW'(FIFO_DEPTH);

  always_comb begin
    state_n    = state;
    fetch_pc_n = fetch_pc;
    discard_n  = discard;
    case (state)
      S_FETCH: if (gnt_ok) begin
        state_n    = S_WAIT;
        fetch_pc_n = fetch_pc + 32'd4;
      end
      S_WAIT: if (instr_rvalid_ip) begin
        discard_n = 1'b0;
        state_n   = has_space ? S_FETCH : S_FULL;
      end
      S_FULL:  if (has_space) state_n = S_FETCH;
      default: state_n = S_FETCH;
    endcase
    // A fetch granted now, or still in flight, must have its word dropped
    if (redirect_valid_ip) begin
      fetch_pc_n = redirect_pc_ip & ~32'h3;
      if (gnt_ok || (state == S_WAIT && !instr_rvalid_ip)) begin
        state_n   = S_WAIT;
        discard_n = 1'b1;
      end else begin
        state_n   = S_FETCH;
        discard_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      armed    <= 1'b0;
      fetch_pc <= RESET_PC;
      out_pc   <= RESET_PC;
      discard  <= 1'b0;
    end else begin
      state    <= state_n;
      armed    <= 1'b1;
      fetch_pc <= fetch_pc_n;
      discard  <= discard_n;
      if (gnt_ok) out_pc <= fetch_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (redirect_valid_ip) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_instr[wr_ptr] <= instr_rdata_ip;
      fifo_pc[wr_ptr]    <= out_pc;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      instr_data_valid_op <= 1'b0;
      instr_data_op       <= NOP_INSTR;
      pc_op               <= RESET_PC;
      pc4_op              <= RESET_PC + 32'd4;
    end else if (redirect_valid_ip) begin
      instr_data_valid_op <= 1'b0;
      instr_data_op       <= NOP_INSTR;
    end else if (!stall_ip) begin
      if (count != '0) begin
        instr_data_valid_op <= 1'b1;
        instr_data_op       <= fifo_instr[rd_ptr];
        pc_op               <= fifo_pc[rd_ptr];
        pc4_op              <= fifo_pc[rd_ptr] + 32'd4;
      end else if (rsp_ok) begin
        instr_data_valid_op <= 1'b1;
        instr_data_op       <= instr_rdata_ip;
        pc_op               <= out_pc;
        pc4_op              <= out_pc + 32'd4;
      end else begin
        instr_data_valid_op <= 1'b0;
        instr_data_op       <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; a small imem responder returns
// 32'hA000_0000 ^ addr one cycle after each grant.
module tb_if_fetch_stage;
  logic        clock = 1'b0, reset = 1'b0;
  logic        stall_ip = 1'b0, redirect_valid_ip = 1'b0;
  logic [31:0] redirect_pc_ip = '0;
  logic        instr_req_op, instr_gnt_ip = 1'b0, instr_rvalid_ip = 1'b0;
  logic [31:0] instr_addr_op, instr_rdata_ip = '0;
  logic        instr_data_valid_op;
  logic [31:0] instr_data_op, pc_op, pc4_op;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int n_cmp = 0, n_err = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          hold_cnt = 0, gnt_delay = 0;

  if_fetch_stage dut (
    .clock(clock), .reset(reset), .stall_ip(stall_ip),
    .redirect_valid_ip(redirect_valid_ip), .redirect_pc_ip(redirect_pc_ip),
    .instr_req_op(instr_req_op), .instr_addr_op(instr_addr_op),
    .instr_gnt_ip(instr_gnt_ip), .instr_rvalid_ip(instr_rvalid_ip),
    .instr_rdata_ip(instr_rdata_ip), .instr_data_valid_op(instr_data_valid_op),
    .instr_data_op(instr_data_op), .pc_op(pc_op), .pc4_op(pc4_op)
  );

  always #5 clock = ~clock;

  // One clock: drive imem inputs at the negedge, cross the posedge, return at the next negedge.
  task automatic step();
    logic g, r;
    logic [31:0] a;
    instr_rvalid_ip = pend;
    instr_rdata_ip  = pend ? (32'hA000_0000 ^ pend_addr) : 32'h0;
    instr_gnt_ip    = instr_req_op && (hold_cnt >= gnt_delay);
    g = instr_gnt_ip; r = instr_req_op; a = instr_addr_op;
    @(posedge clock);
    pend = 1'b0;
    if (g) begin pend = 1'b1; pend_addr = a; hold_cnt = 0; end
    else if (r) hold_cnt++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall_ip = 1'b0; redirect_valid_ip = 1'b0; redirect_pc_ip = '0;
    instr_gnt_ip = 1'b0; instr_rvalid_ip = 1'b0; instr_rdata_ip = '0;
    pend = 1'b0; hold_cnt = 0; gnt_delay = 0;
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clock); @(negedge clock);
    n_cmp++; if (instr_req_op !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", instr_req_op); end
    n_cmp++; if (instr_addr_op !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", instr_addr_op); end
    n_cmp++; if (instr_data_valid_op !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", instr_data_valid_op); end
    n_cmp++; if (instr_data_op !== NOP) begin n_err++; $display("FAIL rst_data: got %h want %h", instr_data_op, NOP); end
    n_cmp++; if (pc_op !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", pc_op); end
    n_cmp++; if (pc4_op !== 32'h4) begin n_err++; $display("FAIL rst_pc4: got %h want 4", pc4_op); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 6 && !instr_req_op; i++) step();
      n_cmp++; if (instr_req_op !== 1'b1) begin n_err++; $display("FAIL stream_req%0d: got %b want 1", k, instr_req_op); end
      n_cmp++; if (instr_addr_op !== 32'(4*k)) begin n_err++; $display("FAIL stream_addr%0d: got %h want %h", k, instr_addr_op, 32'(4*k)); end
      step();
      for (int i = 0; i < 6 && !instr_data_valid_op; i++) step();
      n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'(4*k)) begin n_err++; $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, instr_data_valid_op, pc_op, 32'(4*k)); end
      n_cmp++; if (instr_data_op !== (32'hA000_0000 ^ 32'(4*k))) begin n_err++; $display("FAIL stream_data%0d: got %h want %h", k, instr_data_op, 32'hA000_0000 ^ 32'(4*k)); end
      n_cmp++; if (pc4_op !== 32'(4*k+4)) begin n_err++; $display("FAIL stream_pc4_%0d: got %h want %h", k, pc4_op, 32'(4*k+4)); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 20 && !(instr_data_valid_op && pc_op == 32'h4); i++) step();
    n_cmp++; if (pc_op !== 32'h4) begin n_err++; $display("FAIL stall_setup: got pc %h want 4", pc_op); end
    stall_ip = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h4) begin n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%h want v=1 pc=4", s, instr_data_valid_op, pc_op); end
    end
    n_cmp++; if (instr_req_op !== 1'b0) begin n_err++; $display("FAIL stall_full_req: got %b want 0", instr_req_op); end
    stall_ip = 1'b0;
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h8 || instr_data_op !== 32'hA000_0008) begin n_err++; $display("FAIL stall_rel8: got v=%b pc=%h d=%h want 1/8/A0000008", instr_data_valid_op, pc_op, instr_data_op); end
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'hC || instr_data_op !== 32'hA000_000C) begin n_err++; $display("FAIL stall_relC: got v=%b pc=%h d=%h want 1/C/A000000C", instr_data_valid_op, pc_op, instr_data_op); end
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h10) begin n_err++; $display("FAIL stall_rel10: got v=%b pc=%h want 1/10", instr_data_valid_op, pc_op); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    for (int i = 0; i < 20 && !(instr_req_op && instr_addr_op == 32'hC); i++) step();
    n_cmp++; if (instr_addr_op !== 32'hC) begin n_err++; $display("FAIL redir_setup: got addr %h want C", instr_addr_op); end
    redirect_valid_ip = 1'b1; redirect_pc_ip = 32'h0000_0103;
    step();
    redirect_valid_ip = 1'b0;
    n_cmp++; if (instr_data_valid_op !== 1'b0 || instr_data_op !== NOP) begin n_err++; $display("FAIL redir_flush: got v=%b d=%h want 0/%h", instr_data_valid_op, instr_data_op, NOP); end
    n_cmp++; if (instr_req_op !== 1'b0) begin n_err++; $display("FAIL redir_wait_req: got %b want 0", instr_req_op); end
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b0) begin n_err++; $display("FAIL redir_drop: got v=%b pc=%h want v=0", instr_data_valid_op, pc_op); end
    n_cmp++; if (instr_req_op !== 1'b1 || instr_addr_op !== 32'h100) begin n_err++; $display("FAIL redir_addr: got req=%b addr=%h want 1/100", instr_req_op, instr_addr_op); end
    for (int i = 0; i < 6 && !instr_data_valid_op; i++) step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h100 || instr_data_op !== 32'hA000_0100) begin n_err++; $display("FAIL redir_first: got v=%b pc=%h d=%h want 1/100/A0000100", instr_data_valid_op, pc_op, instr_data_op); end
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset();
    for (int i = 0; i < 20 && !(instr_req_op && instr_addr_op == 32'h4); i++) step();
    step();
    stall_ip = 1'b1; redirect_valid_ip = 1'b1; redirect_pc_ip = 32'h100;
    step();
    stall_ip = 1'b0; redirect_valid_ip = 1'b0;
    n_cmp++; if (instr_data_valid_op !== 1'b0 || instr_data_op !== NOP) begin n_err++; $display("FAIL rvs_flush: got v=%b d=%h want 0/%h", instr_data_valid_op, instr_data_op, NOP); end
    n_cmp++; if (instr_req_op !== 1'b1 || instr_addr_op !== 32'h100) begin n_err++; $display("FAIL rvs_addr: got req=%b addr=%h want 1/100", instr_req_op, instr_addr_op); end
    for (int i = 0; i < 6 && !instr_data_valid_op; i++) step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h100) begin n_err++; $display("FAIL rvs_first: got v=%b pc=%h want 1/100", instr_data_valid_op, pc_op); end
  endtask

  task automatic test_gnt_delay();
    do_reset();
    for (int i = 0; i < 20 && !(instr_req_op && instr_addr_op == 32'h8); i++) step();
    gnt_delay = 4;
    for (int s = 0; s < 4; s++) begin
      step();
      n_cmp++; if (instr_req_op !== 1'b1 || instr_addr_op !== 32'h8) begin n_err++; $display("FAIL gd_hold%0d: got req=%b addr=%h want 1/8", s, instr_req_op, instr_addr_op); end
    end
    step();
    gnt_delay = 0;
    n_cmp++; if (instr_req_op !== 1'b0) begin n_err++; $display("FAIL gd_granted: got req=%b want 0", instr_req_op); end
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h8) begin n_err++; $display("FAIL gd_pc: got v=%b pc=%h want 1/8", instr_data_valid_op, pc_op); end
    n_cmp++; if (instr_addr_op !== 32'hC) begin n_err++; $display("FAIL gd_next: got addr=%h want C", instr_addr_op); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    step();
    redirect_valid_ip = 1'b1; redirect_pc_ip = 32'hFFFF_FFFC;
    step();
    redirect_valid_ip = 1'b0;
    for (int i = 0; i < 6 && !instr_req_op; i++) step();
    n_cmp++; if (instr_addr_op !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr: got %h want FFFFFFFC", instr_addr_op); end
    step(); step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pc: got v=%b pc=%h want 1/FFFFFFFC", instr_data_valid_op, pc_op); end
    n_cmp++; if (pc4_op !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 0", pc4_op); end
    n_cmp++; if (instr_req_op !== 1'b1 || instr_addr_op !== 32'h0) begin n_err++; $display("FAIL wrap_next: got req=%b addr=%h want 1/0", instr_req_op, instr_addr_op); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    for (int i = 0; i < 20 && !(instr_req_op && instr_addr_op == 32'h4); i++) step();
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (instr_req_op !== 1'b0 || instr_addr_op !== 32'h0) begin n_err++; $display("FAIL riw_req: got req=%b addr=%h want 0/0", instr_req_op, instr_addr_op); end
    n_cmp++; if (instr_data_valid_op !== 1'b0 || instr_data_op !== NOP) begin n_err++; $display("FAIL riw_ifid: got v=%b d=%h want 0/%h", instr_data_valid_op, instr_data_op, NOP); end
    n_cmp++; if (pc_op !== 32'h0 || pc4_op !== 32'h4) begin n_err++; $display("FAIL riw_pc: got pc=%h pc4=%h want 0/4", pc_op, pc4_op); end
    @(posedge clock); @(negedge clock);
    reset = 1'b1;
    step();
    n_cmp++; if (instr_data_valid_op !== 1'b0) begin n_err++; $display("FAIL riw_late: got v=%b want 0", instr_data_valid_op); end
    n_cmp++; if (instr_req_op !== 1'b1 || instr_addr_op !== 32'h0) begin n_err++; $display("FAIL riw_refetch: got req=%b addr=%h want 1/0", instr_req_op, instr_addr_op); end
    step(); step();
    n_cmp++; if (instr_data_valid_op !== 1'b1 || pc_op !== 32'h0 || instr_data_op !== 32'hA000_0000) begin n_err++; $display("FAIL riw_first: got v=%b pc=%h d=%h want 1/0/A0000000", instr_data_valid_op, pc_op, instr_data_op); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_outstanding();
    test_redirect_rvalid_stall();
    test_gnt_delay();
    test_pc_wrap();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
